envelope_follower: RTL and testbench



---
 rtl/envelope_follower.sv | 173 +++++++++++++++++
 tb/tb_envelope_follower.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/envelope_follower.sv
// rtl/envelope_follower.sv - rectify/smooth envelope detector with gate extraction
// Gate FSM and hold counter are built only when ENVELOPE_FOLLOWER_GATE_EN is defined.
module envelope_follower #(
  parameter int CLOCK_SPEED   = 50_000_000,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int CONTROL_WIDTH = 10,
  parameter int OUTPUT_WIDTH  = 10,
  parameter int HYSTERESIS    = 16,
  parameter int HOLD_MS       = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]  sample,
  input  logic [CONTROL_WIDTH-1:0] attack,
  input  logic [CONTROL_WIDTH-1:0] rel,
  input  logic [OUTPUT_WIDTH-1:0]  threshold,
  output logic [OUTPUT_WIDTH-1:0]  envelope,
  output logic                     gate,
  output logic                     gate_rise
);

  localparam int SHIFT = SAMPLE_WIDTH - 1 - OUTPUT_WIDTH;
  localparam int EW    = OUTPUT_WIDTH + 1;

  logic [SAMPLE_WIDTH-1:0] neg_sample;
  logic [SAMPLE_WIDTH-2:0] mag_full;
  logic [SAMPLE_WIDTH-2:0] mag_shifted;
  logic [OUTPUT_WIDTH-1:0] mag_d, mag_q;
  logic                    mag_vld_d, mag_vld_q;

  // Most negative sample has no positive twin; clamp it to full scale.
  always_comb begin
    neg_sample = -sample;
    if (sample == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}) begin
      mag_full = '1;
    end else if (sample[SAMPLE_WIDTH-1]) begin
      mag_full = neg_sample[SAMPLE_WIDTH-2:0];
    end else begin
      mag_full = sample[SAMPLE_WIDTH-2:0];
    end
    mag_shifted = mag_full >> SHIFT;
    mag_d       = sample_valid ? mag_shifted[OUTPUT_WIDTH-1:0] : mag_q;
    mag_vld_d   = sample_valid;
  end

  logic [3:0]              ash, rsh;
  logic [EW-1:0]           mag_x, env_x, diff, step, env_next;
  logic [OUTPUT_WIDTH-1:0] env_d, env_q;

  // Step is bounded by the distance to mag, so the result never overshoots.
  always_comb begin
    ash      = attack[CONTROL_WIDTH-1 -: 4];
    rsh      = rel[CONTROL_WIDTH-1 -: 4];
    mag_x    = {1'b0, mag_q};
    env_x    = {1'b0, env_q};
    diff     = '0;
    step     = '0;
    env_next = env_x;
    if (mag_x > env_x) begin
      diff = mag_x - env_x;
      step = diff >> ash;
      if (step == '0) step = EW'(1);
      env_next = env_x + step;
    end else if (mag_x < env_x) begin
      diff = env_x - mag_x;
      step = diff >> rsh;
      if (step == '0) step = EW'(1);
      env_next = env_x - step;
    end
    env_d = mag_vld_q ? env_next[OUTPUT_WIDTH-1:0] : env_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mag_q     <= '0;
      mag_vld_q <= 1'b0;
      env_q     <= '0;
    end else begin
      mag_q     <= mag_d;
      mag_vld_q <= mag_vld_d;
      env_q     <= env_d;
    end
  end

  assign envelope = env_q;

  logic unused_bits;
  assign unused_bits = ^{attack, rel, neg_sample[SAMPLE_WIDTH-1], mag_shifted, env_next[OUTPUT_WIDTH]};

`ifdef ENVELOPE_FOLLOWER_GATE_EN
  localparam int HOLD_CYCLES = CLOCK_SPEED / 1000 * HOLD_MS;
  localparam int CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        hold_cnt_q;
  logic                    gate_q, gate_rise_q;
  logic [OUTPUT_WIDTH-1:0] close_lvl;

  always_comb begin
    close_lvl = (int'(threshold) > HYSTERESIS) ? threshold - OUTPUT_WIDTH'(HYSTERESIS) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      gate_q      <= 1'b0;
      gate_rise_q <= 1'b0;
    end else begin
      gate_rise_q <= 1'b0;
      if (threshold == '0) begin
        state_q    <= S_IDLE;
        hold_cnt_q <= '0;
        gate_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            gate_q <= 1'b0;
            if (env_q >= threshold) begin
              state_q     <= S_OPEN;
              gate_q      <= 1'b1;
              gate_rise_q <= 1'b1;
            end
          end
          S_OPEN: begin
            gate_q <= 1'b1;
            if (env_q < close_lvl) begin
              state_q    <= S_HOLD;
              hold_cnt_q <= '0;
            end
          end
          S_HOLD: begin
            gate_q     <= 1'b1;
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            // A re-crossing of threshold takes priority over hold expiry.
            if (env_q >= threshold) begin
              state_q <= S_OPEN;
            end else if (hold_cnt_q == HOLD_LAST) begin
              state_q    <= S_IDLE;
              hold_cnt_q <= '0;
              gate_q     <= 1'b0;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            gate_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gate      = gate_q;
  assign gate_rise = gate_rise_q;
`else
  localparam logic [31:0] GATE_CFG = 32'(CLOCK_SPEED ^ HYSTERESIS ^ HOLD_MS);

  logic unused_gate;
  assign unused_gate = ^{threshold, GATE_CFG};
  assign gate        = 1'b0;
  assign gate_rise   = 1'b0;
`endif

endmodule

// File: tb/tb_envelope_follower.sv
// tb/tb_envelope_follower.sv - scoreboard bench for envelope_follower
// Gate expectations follow ENVELOPE_FOLLOWER_GATE_EN; HOLD_CYCLES is 8 here.
module tb_envelope_follower;

`ifdef ENVELOPE_FOLLOWER_GATE_EN
  localparam bit GATE_ON = 1'b1;
`else
  localparam bit GATE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] sample;
  logic [9:0]  attack, rel, threshold;
  logic [9:0]  envelope;
  logic        gate, gate_rise;

  envelope_follower #(
    .CLOCK_SPEED(8000),
    .HOLD_MS    (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .attack      (attack),
    .rel         (rel),
    .threshold   (threshold),
    .envelope    (envelope),
    .gate        (gate),
    .gate_rise   (gate_rise)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rise_cnt = 0;
  int m_env = 0;
  int exp_q[$];
  logic vd1 = 1'b0, vd2 = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_mag(input logic [11:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 2047) v = 2047;
    return v >> 1;
  endfunction

  function automatic int model_step(input int env, input int mag, input int ash, input int rsh);
    int d;
    if (mag > env) begin
      d = (mag - env) >> ash;
      if (d < 1) d = 1;
      return env + d;
    end
    if (mag < env) begin
      d = (env - mag) >> rsh;
      if (d < 1) d = 1;
      return env - d;
    end
    return env;
  endfunction

  task automatic put(input logic [11:0] s);
    sample       = s;
    sample_valid = 1'b1;
    m_env = model_step(m_env, model_mag(s), int'(attack[9:6]), int'(rel[9:6]));
    exp_q.push_back(m_env);
  endtask

  task automatic idle();
    sample_valid = 1'b0;
  endtask

  // Envelope lands two edges after its sample was presented.
  always @(posedge clk) begin
    if (!reset) begin
      vd1 <= 1'b0;
      vd2 <= 1'b0;
    end else begin
      vd1 <= sample_valid;
      vd2 <= vd1;
    end
  end

  always @(negedge clk) begin
    if (gate_rise) rise_cnt++;
    if (vd2) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sb_env", int'(envelope), exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0; sample_valid = 1'b0; sample = '0;
    attack = 10'h000; rel = 10'h3C0; threshold = 10'd512;
    repeat (3) @(negedge clk);
    chk("rst_env", int'(envelope), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_rise", int'(gate_rise), 0);
    reset = 1'b1;

    // Full-scale attack in one update, rise three edges after the first sample.
    for (int k = 0; k < 8; k++) begin
      chk("a_env", int'(envelope), (k >= 2) ? 1023 : 0);
      chk("a_rise", int'(gate_rise), int'(GATE_ON && k == 3));
      chk("a_gate", int'(gate), int'(GATE_ON && k >= 3));
      put(12'h7FE);
      @(negedge clk);
    end

    // Slowest release: one LSB per sample down to zero, no wrap.
    for (int i = 0; i < 1026; i++) begin
      put(12'h000);
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);
    chk("rel_floor", int'(envelope), 0);
    chk("rel_gate", int'(gate), 0);

    // Rectifier edges.
    threshold = 10'd0; attack = 10'h000; rel = 10'h000;
    put(12'h800);
    @(negedge clk); idle();
    @(negedge clk);
    chk("mag_min", int'(envelope), 1023);
    put(12'h001);
    @(negedge clk); idle();
    @(negedge clk);
    chk("mag_one", int'(envelope), 0);

    // Hold expiry: env 520 -> 490 drops below 496, gate lasts 8 hold cycles.
    threshold = 10'd512;
    put(12'd1040);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    chk("h_open", int'(gate), int'(GATE_ON));
    for (int k = 0; k < 13; k++) begin
      chk("h_gate", int'(gate), int'(GATE_ON && k <= 10));
      chk("h_rise", int'(gate_rise), 0);
      if (k == 0) put(12'd980); else idle();
      @(negedge clk);
    end

    // Re-open from hold cycle 3 without a second pulse.
    put(12'd1040);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    chk("r_open", int'(gate), int'(GATE_ON));
    for (int k = 0; k < 15; k++) begin
      chk("r_gate", int'(gate), int'(GATE_ON));
      chk("r_rise", int'(gate_rise), 0);
      if (k == 0) put(12'd980);
      else if (k == 4) put(12'd1040);
      else idle();
      @(negedge clk);
    end

    // Threshold zero closes the gate on the next edge.
    threshold = 10'd0;
    @(negedge clk);
    chk("t0_gate", int'(gate), 0);
    chk("t0_rise", int'(gate_rise), 0);
    put(12'h000);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    threshold = 10'd512;
    repeat (2) @(negedge clk);
    chk("t0_after_gate", int'(gate), 0);
    chk("t0_after_rise", int'(gate_rise), 0);

    // Reset mid-attack at env 300 discards the in-flight sample.
    put(12'd600);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    chk("pre_rst_env", int'(envelope), 300);
    attack = 10'h3C0;
    put(12'h7FE);
    @(negedge clk);
    reset = 1'b0; sample = 12'h7FE; sample_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_env", int'(envelope), 0);
    chk("mid_rst_gate", int'(gate), 0);
    chk("mid_rst_rise", int'(gate_rise), 0);
    exp_q.delete();
    m_env = 0;
    reset = 1'b1; sample_valid = 1'b0;

    attack = 10'h000;
    put(12'h7FE);
    @(negedge clk); idle();
    repeat (4) @(negedge clk);
    chk("rec_env", int'(envelope), 1023);
    chk("rec_gate", int'(gate), int'(GATE_ON));
    chk("rise_total", rise_cnt, GATE_ON ? 4 : 0);
    chk("sb_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
